// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Branch/jump targets are decoded from the instruction already held in IF/ID so a
// redirect takes effect on the same edge the hazard unit flushes.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_ld,
    input  logic        IF_ID_write,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid,
    output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 6;
    localparam logic [OP_W-1:0] OP_J   = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE = 6'b000101;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;
    logic [OP_W-1:0] id_op;
    logic [XLEN-1:0] br_offset;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign id_op     = instr_q[31:26];
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Redirect target decoded from the instruction sitting in IF/ID
    always_comb begin
        target = pc_plus4;
        case (id_op)
            OP_J:           target = {pc4_q[31:28], instr_q[25:0], 2'b00};
            OP_BEQ, OP_BNE: target = pc4_q + br_offset;
            default:        target = pc_plus4;
        endcase
    end

    // Next-state selection: stall, redirect, fetch, or hold on illegal write-disable
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!pc_ld) begin
            // flush is ignored while stalled; compare data is not yet valid
            if (IF_ID_write) begin
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end else if (flush) begin
            pc_d    = target;
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (IF_ID_write) begin
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
        // pc_ld=1, IF_ID_write=0, flush=0: hold everything so the fetch is not lost
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign IF_ID_instr    = instr_q;
    assign IF_ID_pc_plus4 = pc4_q;
    assign IF_ID_valid    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_ld && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
        if (pc_ld && flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + XLEN'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
